// File: rtl/g_cbudcle.sv
// Loadable up/down counter with clock enable, cascade carry and async clear.
// Define G_CBUDCLE_SATURATE_EN to hold at the terminal state instead of wrapping.
module g_cbudcle #(
  parameter int WIDTH = 8
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             CE,
  input  logic             LD,
  input  logic             UP,
  input  logic             CI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_count;
  logic             w_term;

  assign w_term = UP ? (r_q == {WIDTH{1'b1}}) : (r_q == {WIDTH{1'b0}});

  always_comb begin
    w_count = UP ? (r_q + ONE) : (r_q - ONE);
`ifdef G_CBUDCLE_SATURATE_EN
    if (w_term) w_count = r_q;
`endif
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      r_q <= '0;
    end else if (CE) begin
      if (LD)      r_q <= D;
      else if (CI) r_q <= w_count;
    end
  end

  // Carry-out ignores CE/LD so a cascade ripples within one cycle.
  assign CO = CI & w_term;
  assign Q  = r_q;

endmodule

// File: tb/tb_g_cbudcle.sv
// Directed self-checking bench for g_cbudcle: 8-bit instance plus a 2x4-bit cascade.
module tb_g_cbudcle;

  logic       clk = 1'b0;
  logic       cd, ce, ld, up, ci;
  logic [7:0] d;
  logic [7:0] q;
  logic       co;

  logic       c_cd, c_ce, c_ld, c_up;
  logic [7:0] c_d;
  logic [3:0] q_lo, q_hi;
  logic       co_lo, co_hi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  g_cbudcle #(.WIDTH(8)) dut (
    .CK(clk), .CD(cd), .CE(ce), .LD(ld), .UP(up), .CI(ci), .D(d), .Q(q), .CO(co)
  );

  g_cbudcle #(.WIDTH(4)) u_lo (
    .CK(clk), .CD(c_cd), .CE(c_ce), .LD(c_ld), .UP(c_up), .CI(1'b1),
    .D(c_d[3:0]), .Q(q_lo), .CO(co_lo)
  );

  g_cbudcle #(.WIDTH(4)) u_hi (
    .CK(clk), .CD(c_cd), .CE(c_ce), .LD(c_ld), .UP(c_up), .CI(co_lo),
    .D(c_d[7:4]), .Q(q_hi), .CO(co_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load8(input logic [7:0] v);
    ce = 1'b1; ld = 1'b1; d = v;
    tick();
    ld = 1'b0;
  endtask

  initial begin
    cd = 1'b1; ce = 1'b0; ld = 1'b0; up = 1'b0; ci = 1'b0; d = 8'h00;
    c_cd = 1'b1; c_ce = 1'b0; c_ld = 1'b0; c_up = 1'b1; c_d = 8'h00;
    #1;
    chk("reset_q", {24'd0, q}, 32'h00);
    #20;
    cd = 1'b0; c_cd = 1'b0;

    // Async clear between edges
    load8(8'h5A);
    chk("load_5a", {24'd0, q}, 32'h5A);
    #2; cd = 1'b1; #1;
    chk("async_clr", {24'd0, q}, 32'h00);
    ci = 1'b1; up = 1'b0; #1;
    chk("reset_co", {31'd0, co}, 32'd1);
    ce = 1'b1; ld = 1'b1; d = 8'h77;
    tick();
    chk("clr_held", {24'd0, q}, 32'h00);
    ld = 1'b0; #2; cd = 1'b0;

    // Load priority over count, CE gating
    ce = 1'b1; ld = 1'b1; ci = 1'b1; up = 1'b1; d = 8'hF0;
    tick();
    chk("load_prio", {24'd0, q}, 32'hF0);
    ce = 1'b0; ld = 1'b1; d = 8'h11;
    tick();
    chk("ce_hold", {24'd0, q}, 32'hF0);
    ld = 1'b0;

    // Up wrap
    load8(8'hFD);
    up = 1'b1; ci = 1'b1; #1;
    chk("up_co_fd", {31'd0, co}, 32'd0);
    tick();
    chk("up_fe", {24'd0, q}, 32'hFE);
    chk("up_co_fe", {31'd0, co}, 32'd0);
    tick();
    chk("up_ff", {24'd0, q}, 32'hFF);
    chk("up_co_ff", {31'd0, co}, 32'd1);
    ci = 1'b0; #1;
    chk("co_needs_ci", {31'd0, co}, 32'd0);
    tick();
    chk("ci_hold", {24'd0, q}, 32'hFF);
    ci = 1'b1; #1;
    tick();
`ifdef G_CBUDCLE_SATURATE_EN
    chk("up_sat", {24'd0, q}, 32'hFF);
    chk("up_sat_co", {31'd0, co}, 32'd1);
`else
    chk("up_wrap", {24'd0, q}, 32'h00);
    chk("up_wrap_co", {31'd0, co}, 32'd0);
`endif

    // Down wrap
    load8(8'h01);
    up = 1'b0; #1;
    chk("dn_co_01", {31'd0, co}, 32'd0);
    tick();
    chk("dn_00", {24'd0, q}, 32'h00);
    chk("dn_co_00", {31'd0, co}, 32'd1);
    up = 1'b1; #1;
    chk("dir_co_only", {31'd0, co}, 32'd0);
    chk("dir_q_only", {24'd0, q}, 32'h00);
    up = 1'b0; #1;
    tick();
`ifdef G_CBUDCLE_SATURATE_EN
    chk("dn_sat", {24'd0, q}, 32'h00);
    chk("dn_sat_co", {31'd0, co}, 32'd1);
`else
    chk("dn_wrap", {24'd0, q}, 32'hFF);
    chk("dn_wrap_co", {31'd0, co}, 32'd0);
`endif

    // Load at terminal state wins; CO reflects pre-edge Q
    load8(8'hFF);
    up = 1'b1; #1;
    chk("term_co", {31'd0, co}, 32'd1);
    ld = 1'b1; d = 8'h3C;
    tick();
    ld = 1'b0;
    chk("term_load", {24'd0, q}, 32'h3C);

    // Async clear mid-count, release, resume
    load8(8'h10);
    up = 1'b1; ci = 1'b1;
    tick();
    chk("mid_11", {24'd0, q}, 32'h11);
    #2; cd = 1'b1; #1;
    chk("mid_clr", {24'd0, q}, 32'h00);
    tick();
    chk("mid_clr_edge", {24'd0, q}, 32'h00);
    #2; cd = 1'b0;
    tick();
    chk("mid_resume", {24'd0, q}, 32'h01);

    // Two-stage cascade
    c_ce = 1'b1; c_ld = 1'b1; c_up = 1'b1; c_d = 8'h0E;
    tick();
    c_ld = 1'b0;
    chk("cas_0e", {24'd0, q_hi, q_lo}, 32'h0E);
    chk("cas_co_0e", {31'd0, co_lo}, 32'd0);
    tick();
    chk("cas_0f", {24'd0, q_hi, q_lo}, 32'h0F);
    chk("cas_co_0f", {31'd0, co_lo}, 32'd1);
    tick();
    chk("cas_10", {24'd0, q_hi, q_lo}, 32'h10);
    chk("cas_co_10", {31'd0, co_lo}, 32'd0);
    tick();
    chk("cas_11", {24'd0, q_hi, q_lo}, 32'h11);
    chk("cas_co_hi", {31'd0, co_hi}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
